// File: rtl/enable_load_capture_bank.sv
// enable_load_capture_bank
// Keeps one accumulator per sequencer step. While a step's enable bit is high,
// its accumulator folds in input words. A load pulse flushes the accumulator,
// tagged with its step index, into a small output FIFO. The FIFO then hands
// entries to the next stage through a valid/ready handshake.
//
// Optional feature macro: CAPTURE_BANK_ACC_XOR_EN
//   defined   : the accumulator XOR-folds every enabled word
//   undefined : the accumulator keeps the last enabled word
//
// Handshake: the FIFO head is offered while o_valid=1. It is consumed at a
// rising edge where o_valid and i_ready are both high. The head holds stable
// until then. Input buses are qualified by i_valid only; there is no
// back-pressure toward the sequencer. A flush that arrives while the FIFO is
// full and not popping is dropped, and this is recorded in o_overflow.
module enable_load_capture_bank #(
  parameter int N_STEPS         = 5,
  parameter int LOG2_N_STEPS    = 3,
  parameter int NB_DATA         = 128,
  parameter int FIFO_DEPTH      = 4,
  parameter int LOG2_FIFO_DEPTH = 2
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic [N_STEPS-1:0]      i_enable_bus,
  input  logic [N_STEPS-1:0]      i_load_bus,
  input  logic [NB_DATA-1:0]      i_data,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [NB_DATA-1:0]      o_data,
  output logic [LOG2_N_STEPS-1:0] o_step,
  output logic                    o_overflow,
  output logic                    o_protocol_err
);

  logic [NB_DATA-1:0]      acc [N_STEPS];
  logic [NB_DATA-1:0]      fifo_data [FIFO_DEPTH];
  logic [LOG2_N_STEPS-1:0] fifo_step [FIFO_DEPTH];
  logic [LOG2_FIFO_DEPTH-1:0] wr_ptr;
  logic [LOG2_FIFO_DEPTH-1:0] rd_ptr;
  logic [LOG2_FIFO_DEPTH:0]   count;

  logic                    en_multi;
  logic                    ld_multi;
  logic                    en_ok;
  logic                    ld_ok;
  logic                    pop;
  logic                    full;
  logic                    push_ok;
  logic [NB_DATA-1:0]      push_data;
  logic [LOG2_N_STEPS-1:0] push_step;

  // Folding function applied to an enabled word.
  function automatic logic [NB_DATA-1:0] fold(input logic [NB_DATA-1:0] a,
                                              input logic [NB_DATA-1:0] d);
`ifdef CAPTURE_BANK_ACC_XOR_EN
    return a ^ d;
`else
    return d;
`endif
  endfunction

  // More than one bit set: bus & (bus-1) keeps every bit except the lowest.
  function automatic logic multi_hot(input logic [N_STEPS-1:0] bus);
    return (bus & (bus - N_STEPS'(1))) != '0;
  endfunction

  assign en_multi = multi_hot(i_enable_bus);
  assign ld_multi = multi_hot(i_load_bus);
  assign en_ok    = i_valid && (i_enable_bus != '0) && !en_multi;
  assign ld_ok    = i_valid && (i_load_bus != '0) && !ld_multi;

  assign o_valid  = (count != '0);
  assign full     = (count == (LOG2_FIFO_DEPTH+1)'(FIFO_DEPTH));
  assign pop      = o_valid && i_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok  = ld_ok && (!full || pop);
  assign o_data   = o_valid ? fifo_data[rd_ptr] : '0;
  assign o_step   = o_valid ? fifo_step[rd_ptr] : '0;

  // Select the flushed step. An enable on that same step folds in first.
  always_comb begin
    push_data = '0;
    push_step = '0;
    for (int k = 0; k < N_STEPS; k++) begin
      if (i_load_bus[k]) begin
        push_step = LOG2_N_STEPS'(k);
        push_data = (en_ok && i_enable_bus[k]) ? fold(acc[k], i_data) : acc[k];
      end
    end
  end

  // Per-step accumulators: a flush clears the step, otherwise an enable folds.
  always_ff @(posedge i_clock) begin
    for (int k = 0; k < N_STEPS; k++) begin
      if (i_reset)
        acc[k] <= '0;
      else if (ld_ok && i_load_bus[k])
        acc[k] <= '0;
      else if (en_ok && i_enable_bus[k])
        acc[k] <= fold(acc[k], i_data);
    end
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_step[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_step[wr_ptr] <= push_step;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        count <= count + 1'b1;
      else if (!push_ok && pop)
        count <= count - 1'b1;
    end
  end

  // Sticky error flags; only reset clears them.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_overflow     <= 1'b0;
      o_protocol_err <= 1'b0;
    end else begin
      if (ld_ok && full && !pop)
        o_overflow <= 1'b1;
      if (i_valid && (en_multi || ld_multi))
        o_protocol_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_enable_load_capture_bank.sv
// Bench for enable_load_capture_bank: directed scenarios with literal
// expectations, followed by randomized traffic. Every cycle is compared
// against a queue-based reference model.
module tb_enable_load_capture_bank;

  localparam int NS = 5;
  localparam int NB = 128;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [NS-1:0] en_bus;
  logic [NS-1:0] ld_bus;
  logic [NB-1:0] data;
  logic          ready;
  logic          o_valid;
  logic [NB-1:0] o_data;
  logic [2:0]    o_step;
  logic          o_overflow;
  logic          o_protocol_err;

  always #5 clk = ~clk;

  enable_load_capture_bank dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_valid        (valid),
    .i_enable_bus   (en_bus),
    .i_load_bus     (ld_bus),
    .i_data         (data),
    .i_ready        (ready),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .o_step         (o_step),
    .o_overflow     (o_overflow),
    .o_protocol_err (o_protocol_err)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]    step;
    logic [NB-1:0] data;
  } ent_t;

  logic [NB-1:0] m_acc [NS];
  ent_t          m_q[$];
  logic [NB-1:0] exp_q[$];
  logic          m_ovf;
  logic          m_perr;
  logic          started = 1'b0;
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic logic [NB-1:0] f_model(input logic [NB-1:0] a, input logic [NB-1:0] d);
`ifdef CAPTURE_BANK_ACC_XOR_EN
    return a ^ d;
`else
    return d;
`endif
  endfunction

  // Index of the single set bit, or -1 when the bus is not one-hot.
  function automatic int onehot_idx(input logic [NS-1:0] bus);
    if ($countones(bus) != 1) return -1;
    for (int i = 0; i < NS; i++) if (bus[i]) return i;
    return -1;
  endfunction

  // Apply the specified behaviour for one rising edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) m_acc[i] = '0;
      m_q.delete();
      m_ovf   = 1'b0;
      m_perr  = 1'b0;
      started = 1'b1;
    end else if (started) begin
      int e, l;
      bit do_pop;
      e = valid ? onehot_idx(en_bus) : -1;
      l = valid ? onehot_idx(ld_bus) : -1;
      do_pop = (m_q.size() > 0) && ready;
      if (valid && ($countones(en_bus) > 1 || $countones(ld_bus) > 1)) m_perr = 1'b1;
      if (do_pop) void'(m_q.pop_front());
      if (e >= 0) m_acc[e] = f_model(m_acc[e], data);
      if (l >= 0) begin
        ent_t ent;
        ent.step = 3'(l);
        ent.data = m_acc[l];
        m_acc[l] = '0;
        if (m_q.size() < DEPTH) m_q.push_back(ent);
        else m_ovf = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (started) begin
      check("o_valid", NB'(o_valid), NB'(m_q.size() != 0));
      check("o_data", o_data, (m_q.size() != 0) ? m_q[0].data : '0);
      check("o_step", NB'(o_step), (m_q.size() != 0) ? NB'(m_q[0].step) : '0);
      check("o_overflow", NB'(o_overflow), NB'(m_ovf));
      check("o_protocol_err", NB'(o_protocol_err), NB'(m_perr));
    end
  end

  // ---------------- driver ----------------
  // Drive the inputs on the falling edge and return just after the next
  // rising edge, so the effects of this cycle are already visible.
  task automatic cyc(input logic v, input logic [NS-1:0] en, input logic [NS-1:0] ld,
                     input logic [NB-1:0] d, input logic rdy, input logic r = 1'b0);
    @(negedge clk);
    valid = v; en_bus = en; ld_bus = ld; data = d; ready = rdy; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b1);
  endtask

  function automatic logic [NB-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [NB-1:0] exp_w;
    logic [NB-1:0] r0;
    logic [NB-1:0] r2;
    rst = 1'b1; valid = 1'b0; en_bus = '0; ld_bus = '0; data = '0; ready = 1'b0;
    do_reset();
    do_reset();
    check("reset_valid", NB'(o_valid), '0);
    check("reset_data", o_data, '0);
    check("reset_flags", NB'({o_overflow, o_protocol_err}), '0);

    // Accumulate into step 2, then flush it.
    cyc(1, 5'b00100, '0, 128'h11, 1);
    cyc(1, 5'b00100, '0, 128'h22, 1);
    cyc(1, 5'b00100, '0, 128'h44, 1);
    cyc(1, '0, 5'b00100, '0, 1);
`ifdef CAPTURE_BANK_ACC_XOR_EN
    exp_w = 128'h77;
`else
    exp_w = 128'h44;
`endif
    check("flush_valid", NB'(o_valid), NB'(1));
    check("flush_step", NB'(o_step), NB'(2));
    check("flush_data", o_data, exp_w);
    cyc(1, '0, 5'b00100, '0, 1);
    check("reflush_step", NB'(o_step), NB'(2));
    check("reflush_data", o_data, '0);
    cyc(0, '0, '0, '0, 1);
    check("drained", NB'(o_valid), '0);

    // Five flushes into a four-entry FIFO with the consumer stalled.
    for (int k = 0; k < NS; k++) cyc(1, 5'(1 << k), '0, rand_word(), 0);
    for (int k = 0; k < NS; k++) cyc(1, '0, 5'(1 << k), '0, 0);
    check("ovf_set", NB'(o_overflow), NB'(1));
    for (int k = 0; k < DEPTH; k++) begin
      check("ovf_head_step", NB'(o_step), NB'(k));
      cyc(0, '0, '0, '0, 1);
    end
    check("ovf_empty", NB'(o_valid), '0);

    // A flush into a full FIFO is accepted when the head pops in the same cycle.
    do_reset();
    for (int k = 0; k < DEPTH; k++) cyc(1, '0, 5'(1 << k), '0, 0);
    cyc(1, 5'b00010, 5'b00010, 128'hABC, 1);
    check("full_pop_push_ovf", NB'(o_overflow), '0);
    check("full_pop_push_head", NB'(o_step), NB'(1));
    for (int k = 0; k < DEPTH; k++) begin
      exp_q.push_back(m_q[k].data);
    end
    for (int k = 0; k < DEPTH; k++) begin
      check("full_pop_push_drain", o_data, exp_q.pop_front());
      cyc(0, '0, '0, '0, 1);
    end
    check("full_pop_push_last", NB'(o_valid), '0);

    // A multi-hot load bus pushes nothing and leaves both accumulators intact.
    do_reset();
    r0 = rand_word();
    r2 = rand_word();
    cyc(1, 5'b00001, '0, r0, 1);
    cyc(1, 5'b00100, '0, r2, 1);
    cyc(1, '0, 5'b00101, '0, 1);
    check("multi_no_push", NB'(o_valid), '0);
    check("multi_err", NB'(o_protocol_err), NB'(1));
    cyc(1, '0, 5'b00001, '0, 1);
    check("multi_acc0", o_data, f_model('0, r0));
    cyc(1, '0, 5'b00100, '0, 1);
    check("multi_acc2", o_data, f_model('0, r2));

    // A reset in the middle of accumulation clears the step.
    cyc(1, 5'b01000, '0, rand_word(), 0);
    cyc(1, '0, 5'b00001, '0, 0);
    do_reset();
    check("midreset_out", NB'({o_valid, o_overflow, o_protocol_err}), '0);
    cyc(1, '0, 5'b01000, '0, 1);
    check("midreset_flush", o_data, '0);
    check("midreset_step", NB'(o_step), NB'(3));

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [NS-1:0] e, l;
      int re, rl;
      re = $urandom_range(0, 9);
      rl = $urandom_range(0, 11);
      e = (re < 5) ? 5'(1 << re) : ((re == 9 && $urandom_range(0, 40) == 0) ? 5'($urandom()) : '0);
      l = (rl < 5) ? 5'(1 << rl) : ((rl == 11 && $urandom_range(0, 40) == 0) ? 5'($urandom()) : '0);
      cyc($urandom_range(0, 3) != 0, e, l, rand_word(), $urandom_range(0, 2) != 0,
          $urandom_range(0, 250) == 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enable_load_capture_bank.md
# enable_load_capture_bank

Downstream consumer of the enable/load sequencer's per-step control buses. Keeps one data accumulator per step: a step's accumulator folds in input words while that step's enable bit is high, and is flushed when that step's load pulse arrives. Flushed results, tagged with their step index, are queued in a small output FIFO with a valid/ready handshake toward the next stage.

## Interface
- N_STEPS, 5, number of steps; width of the enable and load buses
- LOG2_N_STEPS, 3, width of the step tag
- NB_DATA, 128, data word width
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2
- LOG2_FIFO_DEPTH, 2, FIFO pointer width
- i_clock  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  clock-enable qualifier for i_enable_bus, i_load_bus and i_data
- i_enable_bus  in  N_STEPS  per-step accumulate enable, at most one bit high
- i_load_bus  in  N_STEPS  per-step flush pulse, at most one bit high
- i_data  in  NB_DATA  input data word
- i_ready  in  1  downstream accepts the FIFO head
- o_valid  out  1  FIFO not empty
- o_data  out  NB_DATA  FIFO head data; 0 when empty
- o_step  out  LOG2_N_STEPS  step index of FIFO head; 0 when empty
- o_overflow  out  1  sticky: a flush was dropped because the FIFO was full
- o_protocol_err  out  1  sticky: more than one bit was high on the enable bus or the load bus

## Operation
- Accumulators acc[0..N_STEPS-1] are NB_DATA-bit registers; all reset to 0.
- Accumulate: when i_valid and i_enable_bus[k] are both high, acc[k] <= f(acc[k], i_data). f is XOR, or plain overwrite; see Configuration.
- Flush: when i_valid and i_load_bus[k] are both high, with exactly one load bit set:
  - push {k, acc[k]} into the FIFO;
  - clear acc[k] to 0.
- Enable and load on the same k in the same cycle: the pushed value is f(acc[k], i_data), and acc[k] becomes 0.
- Enable on j and load on k, j≠k, in the same cycle: both actions happen independently.
- Multi-hot load bus: no push, no clear, o_protocol_err set.
- Multi-hot enable bus: no accumulate, o_protocol_err set.
- While i_valid is low, the enable and load buses are ignored.
- Pop: the FIFO pops when o_valid and i_ready are both high. Pop is independent of i_valid.
- Full FIFO:
  - a push with no simultaneous pop is dropped, o_overflow is set, and acc[k] is still cleared;
  - a push with a simultaneous pop is accepted.
- Empty FIFO with a push: the entry becomes visible next cycle. There is no same-cycle bypass.
- Sticky flags clear only on i_reset.
- Widths:
  - FIFO occupancy counter is LOG2_FIFO_DEPTH+1 bits;
  - pointers wrap modulo FIFO_DEPTH.

## Timing
- Every output is 0 in the cycle after a reset cycle.
- Flush latency: load sampled at edge t gives o_valid=1 with the data after edge t, so it is visible in cycle t+1.
- An accumulate at edge t is visible to a flush at edge t+1. This matches the sequencer, whose last enable cycle is directly followed by its pulse cycle.
- The head holds stable while o_valid=1 and i_ready=0.
- Back-to-back flushes with i_ready held at 1 give one output per cycle, with no loss.
- Reset in the middle of operation:
  - accumulators, FIFO contents, pointers and flags are all cleared;
  - a load or pop in the reset cycle is ignored.

## Configuration
- CAPTURE_BANK_ACC_XOR_EN
  - Defined: f = acc[k] ^ i_data. The accumulator XOR-folds every enabled word.
  - Undefined: f = i_data. The accumulator holds the last enabled word, so a flush returns the last sample of the step.
  - Flush, clear, FIFO and error behaviour are identical in both builds.

## Test plan
- XOR build; enable[2] with data 0x11, 0x22, 0x44 on consecutive valid cycles; then load[2]; i_ready=1 → o_valid for 1 cycle with o_step=2, o_data=0x77; acc[2] reads 0 afterwards.
- Non-XOR build, same stimulus → o_data=0x44.
- i_ready=0; 5 flushes on steps 0..4 with FIFO_DEPTH=4 → 4 entries held in order 0,1,2,3; o_overflow=1 after the 5th; then i_ready=1 → heads 0,1,2,3, then o_valid=0.
- Full FIFO, i_ready=1, load[1] in the same cycle → both the pop and the push are accepted; o_overflow stays 0.
- i_load_bus=5'b00101 with i_valid=1 → no push; o_protocol_err=1; acc[0] and acc[2] unchanged.
- Accumulate then i_reset pulse mid-stream → all outputs 0; a following flush of that step returns 0.
